// File: rtl/muldiv.sv
// Iterative HI/LO multiply/divide unit: radix-2 shift-add multiply and restoring divide, one bit per cycle.
// Define MULDIV_DIV_EN to build the divider datapath in; otherwise DIV/DIVU requests are ignored.
module muldiv #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         whi,
    input  logic         wlo,
    input  logic [N-1:0] wdata,
    output logic         busy,
    output logic [N-1:0] hi,
    output logic [N-1:0] lo
);

    localparam int CW = ($clog2(N) < 1) ? 1 : $clog2(N);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]     state = IDLE;
    logic [CW-1:0]  cnt   = '0;
    logic [N-1:0]   hi_r  = '0;
    logic [N-1:0]   lo_r  = '0;
    logic [N-1:0]   m     = '0;
    logic [2*N-1:0] p     = '0;
    logic           neg_res = 1'b0;
`ifdef MULDIV_DIV_EN
    logic           is_div  = 1'b0;
    logic           neg_rem = 1'b0;
    logic [N-1:0]   a_raw   = '0;
    logic [N:0]     shifted;
    logic [N:0]     diff;
    logic [N-1:0]   quo;
    logic [N-1:0]   rem;
`endif

    logic           accept;
    logic           sgn, a_neg, b_neg;
    logic [N-1:0]   a_mag, b_mag;
    logic [N:0]     mul_sum;
    logic [2*N-1:0] p_next;
    logic [2*N-1:0] prod;
    logic [N-1:0]   res_hi, res_lo;

    assign busy = (state == RUN);
    assign hi   = hi_r;
    assign lo   = lo_r;

    always_comb begin
        sgn   = ~op[0];
        a_neg = sgn & a[N-1];
        b_neg = sgn & b[N-1];
        a_mag = a_neg ? -a : a;
        b_mag = b_neg ? -b : b;
`ifdef MULDIV_DIV_EN
        accept = start && (state == IDLE);
`else
        accept = start && (state == IDLE) && !op[1];
`endif
    end

    // p holds {partial product, multiplier} or {partial remainder, dividend/quotient}
    always_comb begin
        mul_sum = {1'b0, p[2*N-1:N]} + (p[0] ? {1'b0, m} : '0);
        p_next  = {mul_sum, p[N-1:1]};
`ifdef MULDIV_DIV_EN
        shifted = p[2*N-1:N-1];
        diff    = shifted - {1'b0, m};
        if (is_div) begin
            if (!diff[N])
                p_next = {diff[N-1:0], p[N-2:0], 1'b1};
            else
                p_next = {shifted[N-1:0], p[N-2:0], 1'b0};
        end
`endif
    end

    always_comb begin
        prod   = neg_res ? -p_next : p_next;
        res_hi = prod[2*N-1:N];
        res_lo = prod[N-1:0];
`ifdef MULDIV_DIV_EN
        quo = neg_res ? -p_next[N-1:0]   : p_next[N-1:0];
        rem = neg_rem ? -p_next[2*N-1:N] : p_next[2*N-1:N];
        if (is_div) begin
            // divisor magnitude zero: all-ones quotient, dividend passed through as remainder
            if (m == '0) begin
                res_hi = a_raw;
                res_lo = '1;
            end else begin
                res_hi = rem;
                res_lo = quo;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            hi_r    <= '0;
            lo_r    <= '0;
            m       <= '0;
            p       <= '0;
            neg_res <= 1'b0;
`ifdef MULDIV_DIV_EN
            is_div  <= 1'b0;
            neg_rem <= 1'b0;
            a_raw   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state   <= RUN;
                        cnt     <= '0;
                        neg_res <= a_neg ^ b_neg;
`ifdef MULDIV_DIV_EN
                        is_div  <= op[1];
                        neg_rem <= a_neg;
                        a_raw   <= a;
                        m       <= op[1] ? b_mag : a_mag;
                        p       <= {{N{1'b0}}, (op[1] ? a_mag : b_mag)};
`else
                        m       <= a_mag;
                        p       <= {{N{1'b0}}, b_mag};
`endif
                    end else begin
                        if (whi) hi_r <= wdata;
                        if (wlo) lo_r <= wdata;
                    end
                end
                default: begin
                    p   <= p_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(N - 1)) begin
                        state <= IDLE;
                        hi_r  <= res_hi;
                        lo_r  <= res_lo;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv.sv
// Scoreboard bench for muldiv: stimulus queues expected HI/LO, a monitor checks them when busy falls.
module tb_muldiv;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0, b = '0;
    logic        whi = 1'b0, wlo = 1'b0;
    logic [31:0] wdata = '0;
    logic        busy;
    logic [31:0] hi, lo;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    logic [63:0] exp_q[$];
    logic [31:0] cur_hi = '0, cur_lo = '0;
    logic        prev_busy = 1'b0;

    muldiv #(.N(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .whi(whi), .wlo(wlo), .wdata(wdata), .busy(busy), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // monitor: every busy falling edge retires one queued expectation
    always @(negedge clk) begin
        if (prev_busy && !busy) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_result: hi=%h lo=%h with no expectation queued", hi, lo);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if ({hi, lo} !== e) begin
                    miscompares++;
                    $display("FAIL result: got hi=%h lo=%h expected hi=%h lo=%h",
                             hi, lo, e[63:32], e[31:0]);
                end
            end
        end
        prev_busy = busy;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] aa, input logic [31:0] bb,
                          input logic [31:0] eh, input logic [31:0] el, input bit strobe);
        int unsigned cycles;
        bit held;
        @(negedge clk);
        start = 1'b1; op = o; a = aa; b = bb;
        exp_q.push_back({eh, el});
        @(negedge clk);
        start = 1'b0;
        if (strobe) begin
            whi = 1'b1; wlo = 1'b1; wdata = 32'hDEAD_BEEF;
        end
        cycles = 0;
        held = 1'b1;
        while (busy && cycles < 100) begin
            cycles++;
            if (hi !== cur_hi || lo !== cur_lo) held = 1'b0;
            @(negedge clk);
        end
        whi = 1'b0; wlo = 1'b0;
        check("busy_cycles", cycles, 32);
        check("hold_during_run", {31'b0, held}, 32'd1);
        cur_hi = eh;
        cur_lo = el;
    endtask

    task automatic check_ignored(input logic [1:0] o, input logic [31:0] aa, input logic [31:0] bb);
        bit stayed_idle;
        @(negedge clk);
        start = 1'b1; op = o; a = aa; b = bb;
        @(negedge clk);
        start = 1'b0;
        stayed_idle = !busy;
        repeat (3) begin
            @(negedge clk);
            if (busy) stayed_idle = 1'b0;
        end
        check("div_ignored_busy", {31'b0, stayed_idle}, 32'd1);
        check("div_ignored_hi", hi, cur_hi);
        check("div_ignored_lo", lo, cur_lo);
    endtask

    initial begin
        bit saw_bad;
        int unsigned guard;

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);

        // MTHI/MTLO in IDLE
        @(negedge clk);
        whi = 1'b1; wlo = 1'b1; wdata = 32'h1234;
        @(negedge clk);
        whi = 1'b0; wlo = 1'b0;
        check("mthi", hi, 32'h1234);
        check("mtlo", lo, 32'h1234);
        cur_hi = 32'h1234; cur_lo = 32'h1234;

        // strobes during RUN must not disturb HI/LO
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b1);
        run_op(2'b00, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0);
        run_op(2'b01, 32'h1234_5678, 32'h10,        32'h0000_0001, 32'h2345_6780, 1'b0);

`ifdef MULDIV_DIV_EN
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op(2'b11, 32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF, 1'b0);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
        run_op(2'b10, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
        run_op(2'b11, 32'hFFFF_FFFF, 32'h10,        32'h0000_000F, 32'h0FFF_FFFF, 1'b0);
        run_op(2'b10, 32'hFFFF_FFF8, 32'd0,         32'hFFFF_FFF8, 32'hFFFF_FFFF, 1'b0);
`else
        check_ignored(2'b10, 32'd10, 32'd2);
        check_ignored(2'b11, 32'd100, 32'd7);
        run_op(2'b01, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0);
`endif

        // start MULTU 5x6, ignored start at cycle 10, reset at cycle 20
        saw_bad = 1'b0;
        @(negedge clk);
        start = 1'b1; op = 2'b01; a = 32'd5; b = 32'd6;
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i < 20; i++) begin
            if (i == 10) begin
                start = 1'b1; op = 2'b01; a = 32'd9; b = 32'd9;
            end else begin
                start = 1'b0;
            end
            if (hi == 32'd30 || lo == 32'd30 || hi == 32'd81 || lo == 32'd81) saw_bad = 1'b1;
            @(negedge clk);
        end
        start = 1'b0;
        check("busy_before_abort", {31'b0, busy}, 32'd1);
        exp_q.push_back(64'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        guard = 0;
        repeat (40) begin
            @(negedge clk);
            if (busy) guard++;
            if (hi == 32'd30 || lo == 32'd30 || hi == 32'd81 || lo == 32'd81) saw_bad = 1'b1;
        end
        check("abort_stays_idle", guard, 32'd0);
        check("no_partial_result", {31'b0, saw_bad}, 32'd0);
        cur_hi = '0; cur_lo = '0;

        run_op(2'b01, 32'd5, 32'd6, 32'd0, 32'd30, 1'b0);

        repeat (2) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/muldiv.md
MULDIV -- requirements
Module: muldiv

Interface
REQ-001 Parameter: N, default 32, operand and HI/LO width in bits.
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  one-cycle operation request from EX stage.
REQ-005 op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled only with start.
REQ-006 a  input  N  rs operand (multiplicand / dividend); sampled only with start.
REQ-007 b  input  N  rt operand (multiplier / divisor); sampled only with start.
REQ-008 whi  input  1  MTHI write strobe.
REQ-009 wlo  input  1  MTLO write strobe.
REQ-010 wdata  input  N  MTHI/MTLO write data.
REQ-011 busy  output  1  operation in progress; pipeline control deasserts pipeline-register we while high.
REQ-012 hi  output  N  HI register (upper product / remainder).
REQ-013 lo  output  N  LO register (lower product / quotient).

Function
REQ-014 Two states, IDLE and RUN; busy SHALL be 1 exactly in RUN.
REQ-015 start in IDLE SHALL latch op, a, b, clear the iteration counter, and enter RUN at the next edge.
REQ-016 RUN SHALL last exactly N cycles (radix-2 shift-add multiply / restoring divide, one bit per cycle), then return to IDLE.
REQ-017 hi/lo SHALL update on the same edge that deasserts busy; they SHALL hold previous values throughout RUN.
REQ-018 MULT/MULTU: {hi,lo} SHALL equal the full 2N-bit signed/unsigned product of a and b.
REQ-019 Signed ops SHALL operate on magnitudes; product and quotient negated when operand signs differ; remainder sign follows dividend.
REQ-020 DIV/DIVU: lo SHALL be quotient, hi remainder, truncating toward zero.
REQ-021 Divide by zero: lo SHALL be all ones, hi SHALL be a; latency unchanged.
REQ-022 DIV of -2^(N-1) by -1: lo SHALL be 2^(N-1) bit pattern, hi SHALL be 0.
REQ-023 start while busy SHALL be ignored; operation in flight unaffected.
REQ-024 whi/wlo in IDLE without start SHALL write wdata to hi/lo at the next edge; both may be written in the same cycle.
REQ-025 whi/wlo while busy, or in the same cycle as an accepted start, SHALL be ignored.
REQ-026 hi/lo SHALL be registered outputs with no combinational path from inputs.

Reset
REQ-027 reset SHALL force IDLE, busy=0, hi=0, lo=0, counter=0 at the next edge, with priority over all inputs.
REQ-028 reset during RUN SHALL abort the operation; no partial result SHALL reach hi/lo.
REQ-029 Power-up initial values SHALL equal reset values.

Configuration
REQ-030 Macro MULDIV_DIV_EN SHALL compile the divider datapath in.
REQ-031 With MULDIV_DIV_EN defined: DIV/DIVU SHALL behave per REQ-020..022.
REQ-032 Without MULDIV_DIV_EN: start with op[1]=1 SHALL be ignored (busy stays 0, hi/lo unchanged); multiply and MTHI/MTLO unaffected.

Verification
REQ-033 MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> busy high 32 cycles, then hi=0xFFFFFFFE, lo=0x00000001.
REQ-034 MULT a=-3 b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB after 32 busy cycles.
REQ-035 DIV a=-7 b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=100 b=0 -> lo=0xFFFFFFFF, hi=100.
REQ-036 start MULTU 5x6, second start (MULTU 9x9) at cycle 10, reset at cycle 20 -> second start ignored; busy=0, hi=lo=0 after reset edge; no 30 or 81 ever appears.
REQ-037 IDLE: whi=1 wlo=1 wdata=0x1234 -> hi=lo=0x1234 next cycle; same strobes during RUN -> no change.
REQ-038 Build without MULDIV_DIV_EN: start DIV 10/2 -> busy stays 0, hi/lo unchanged.
